// File: rtl/reorder_buffer_param.sv
// reorder_buffer_param
// Reorder buffer for the out-of-order MIPS core. Dispatch allocates entries in
// program order, the CDB marks them complete, and the head entry retires in
// order through a valid/ready handshake. A one-cycle flush empties the buffer.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alloc_valid/alloc_ready          allocation handshake (ready = not full)
//   alloc_dest, alloc_is_store       payload of the allocated entry
//   alloc_tag                        tag granted on handshake (tail pointer)
//   cdb_valid/tag/val/exc            completion broadcast
//   commit_valid/commit_ready        retirement handshake on the head entry
//   commit_tag/arch_reg/val/is_store/exc   head entry fields (combinational)
//   flush                            discard all entries
//   count                            current occupancy
//   rd0_*/rd1_*                      operand lookup ports (ROB_OPERAND_READ_EN)
//
// Build option: define ROB_OPERAND_READ_EN to add two combinational operand
// read ports with same-cycle CDB forwarding.

module reorder_buffer_param #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned AREG_W = 5,
   parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [AREG_W-1:0] alloc_dest,
   input  logic              alloc_is_store,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_val,
   input  logic              cdb_exc,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [AREG_W-1:0] commit_arch_reg,
   output logic [DATA_W-1:0] commit_val,
   output logic              commit_is_store,
   output logic              commit_exc,
   input  logic              flush,
   output logic [TAG_W:0]    count
`ifdef ROB_OPERAND_READ_EN
   ,
   input  logic [TAG_W-1:0]  rd0_tag,
   input  logic [TAG_W-1:0]  rd1_tag,
   output logic              rd0_ready,
   output logic              rd1_ready,
   output logic [DATA_W-1:0] rd0_val,
   output logic [DATA_W-1:0] rd1_val
`endif
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]  ent_valid;
   logic [DEPTH-1:0]  ent_ready;
   logic [DEPTH-1:0]  ent_exc;
   logic [DEPTH-1:0]  ent_store;
   logic [AREG_W-1:0] ent_areg [DEPTH];
   logic [DATA_W-1:0] ent_val  [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic              do_alloc;
   logic              do_commit;
   logic              cdb_hit;

   // Full blocks allocation even if the head retires this cycle.
   assign alloc_ready = (count != FULL_CNT);
   assign alloc_tag   = tail;

   // Head entry view; no CDB bypass, so completion shows up a cycle later.
   assign commit_valid    = ent_valid[head] & ent_ready[head];
   assign commit_tag      = head;
   assign commit_arch_reg = ent_areg[head];
   assign commit_val      = ent_val[head];
   assign commit_is_store = ent_store[head];
   assign commit_exc      = ent_exc[head];

   // Flush has priority over every other update in the same cycle.
   assign do_alloc  = alloc_valid & alloc_ready & ~flush;
   assign do_commit = commit_valid & commit_ready & ~flush;
   assign cdb_hit   = cdb_valid & ent_valid[cdb_tag] & ~flush;

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_alloc)  tail <= tail + TAG_W'(1);
         if (do_commit) head <= head + TAG_W'(1);
         case ({do_alloc, do_commit})
            2'b10:   count <= count + (TAG_W+1)'(1);
            2'b01:   count <= count - (TAG_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry state. Allocation and commit never target the same slot: that
   // would need head==tail with the buffer both empty and full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         ent_ready <= '0;
         ent_exc   <= '0;
         ent_store <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_areg[i] <= '0;
            ent_val[i]  <= '0;
         end
      end else if (flush) begin
         ent_valid <= '0;
         ent_ready <= '0;
         ent_exc   <= '0;
      end else begin
         if (cdb_hit) begin
            ent_ready[cdb_tag] <= 1'b1;
            ent_exc[cdb_tag]   <= cdb_exc;
            ent_val[cdb_tag]   <= cdb_val;
         end
         if (do_alloc) begin
            ent_valid[tail] <= 1'b1;
            ent_ready[tail] <= 1'b0;
            ent_exc[tail]   <= 1'b0;
            ent_store[tail] <= alloc_is_store;
            ent_areg[tail]  <= alloc_dest;
         end
         if (do_commit) begin
            ent_valid[head] <= 1'b0;
            ent_ready[head] <= 1'b0;
         end
      end
   end

`ifdef ROB_OPERAND_READ_EN
   logic rd0_fwd;
   logic rd1_fwd;

   // A broadcast on the looked-up tag this cycle forwards straight through.
   assign rd0_fwd   = cdb_valid & ent_valid[rd0_tag] & (cdb_tag == rd0_tag);
   assign rd1_fwd   = cdb_valid & ent_valid[rd1_tag] & (cdb_tag == rd1_tag);
   assign rd0_ready = (ent_valid[rd0_tag] & ent_ready[rd0_tag]) | rd0_fwd;
   assign rd1_ready = (ent_valid[rd1_tag] & ent_ready[rd1_tag]) | rd1_fwd;
   assign rd0_val   = rd0_fwd ? cdb_val : ent_val[rd0_tag];
   assign rd1_val   = rd1_fwd ? cdb_val : ent_val[rd1_tag];
`endif

endmodule
